// File: rtl/controller_sequencer_pkg.sv
// rtl/controller_sequencer_pkg.sv - shared constants for the SAP-1 control sequencer
//
// Holds the opcode map, the T-state encoding and the bit positions of the
// control word, so the decoder, the sequencer and the datapath top level all
// refer to control lines by name.
package controller_sequencer_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_LDI = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'd14;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'd15;

  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4
  } step_t;

  // Control word bit positions. CW_HLT is an internal request, not a datapath line.
  localparam int CW_PC_INC     = 0;
  localparam int CW_PC_OUT     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_LOAD   = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OUT      = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_SUB    = 11;
  localparam int CW_ALU_OUT    = 12;
  localparam int CW_FLAGS_LOAD = 13;
  localparam int CW_OUT_LOAD   = 14;
  localparam int CW_HLT        = 15;
  localparam int CW_WIDTH      = 16;

endpackage

// File: rtl/controller_sequencer_microcode_decode.sv
// rtl/controller_sequencer_microcode_decode.sv - combinational microcode ROM
//
// Ports:
//   step      current T-state
//   opcode    instruction register opcode field (used in T3..T5 only)
//   carry     registered carry flag (JC)
//   zero      registered zero flag (JZ)
//   ctrl      control word, bit positions from the package
//   last_step 1 when the current step ends the instruction
module microcode_decode
  import controller_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  step_t                   step,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry,
  input  logic                    zero,
  output logic [CW_WIDTH-1:0]     ctrl,
  output logic                    last_step
);

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    case (step)
      T1: begin
        ctrl[CW_PC_OUT]   = 1'b1;
        ctrl[CW_MAR_LOAD] = 1'b1;
      end
      T2: begin
        ctrl[CW_RAM_OUT] = 1'b1;
        ctrl[CW_IR_LOAD] = 1'b1;
        ctrl[CW_PC_INC]  = 1'b1;
      end
      default: begin
        // Any execute step past an opcode's length ends it, so an
        // unreachable step can never wedge the counter.
        last_step = 1'b1;
        case (opcode)
          OPCODE_WIDTH'(OP_LDA), OPCODE_WIDTH'(OP_STA): begin
            if (step == T3) begin
              ctrl[CW_IR_OUT]   = 1'b1;
              ctrl[CW_MAR_LOAD] = 1'b1;
              last_step         = 1'b0;
            end else if (step == T4) begin
              if (opcode == OPCODE_WIDTH'(OP_LDA)) begin
                ctrl[CW_RAM_OUT] = 1'b1;
                ctrl[CW_A_LOAD]  = 1'b1;
              end else begin
                ctrl[CW_A_OUT]    = 1'b1;
                ctrl[CW_RAM_LOAD] = 1'b1;
              end
            end
          end
          OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
            if (step == T3) begin
              ctrl[CW_IR_OUT]   = 1'b1;
              ctrl[CW_MAR_LOAD] = 1'b1;
              last_step         = 1'b0;
            end else if (step == T4) begin
              ctrl[CW_RAM_OUT] = 1'b1;
              ctrl[CW_B_LOAD]  = 1'b1;
              last_step        = 1'b0;
            end else if (step == T5) begin
              ctrl[CW_ALU_OUT]    = 1'b1;
              ctrl[CW_A_LOAD]     = 1'b1;
              ctrl[CW_FLAGS_LOAD] = 1'b1;
              ctrl[CW_ALU_SUB]    = (opcode == OPCODE_WIDTH'(OP_SUB));
            end
          end
          OPCODE_WIDTH'(OP_LDI): begin
            if (step == T3) begin
              ctrl[CW_IR_OUT] = 1'b1;
              ctrl[CW_A_LOAD] = 1'b1;
            end
          end
          OPCODE_WIDTH'(OP_JMP), OPCODE_WIDTH'(OP_JC), OPCODE_WIDTH'(OP_JZ): begin
            if (step == T3) begin
              // Flags are taken live, so a flag change inside T3 shows at once.
              if ((opcode == OPCODE_WIDTH'(OP_JMP)) ||
                  ((opcode == OPCODE_WIDTH'(OP_JC)) && carry) ||
                  ((opcode == OPCODE_WIDTH'(OP_JZ)) && zero)) begin
                ctrl[CW_IR_OUT]  = 1'b1;
                ctrl[CW_PC_LOAD] = 1'b1;
              end
            end
          end
          OPCODE_WIDTH'(OP_OUT): begin
            if (step == T3) begin
              ctrl[CW_A_OUT]    = 1'b1;
              ctrl[CW_OUT_LOAD] = 1'b1;
            end
          end
          OPCODE_WIDTH'(OP_HLT): begin
            if (step == T3) begin
              ctrl[CW_HLT] = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 T-state sequencer with sticky halt
//
// Ports:
//   mclk, rst_n           clock, asynchronous active-low reset
//   mclk_en               clock enable for the step and halt registers
//   i_opcode              instruction register opcode field
//   i_flag_carry/zero     registered ALU flags
//   o_step                current T-state (0=T1 .. 4=T5)
//   o_pc_* .. o_out_load  datapath control lines (combinational)
//   o_halt                sticky halt, also the program counter halt input
module controller_sequencer
  import controller_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    mclk,
  input  logic                    rst_n,
  input  logic                    mclk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic                    i_flag_carry,
  input  logic                    i_flag_zero,
  output logic [2:0]              o_step,
  output logic                    o_pc_inc,
  output logic                    o_pc_out,
  output logic                    o_pc_load,
  output logic                    o_mar_load,
  output logic                    o_ram_out,
  output logic                    o_ram_load,
  output logic                    o_ir_load,
  output logic                    o_ir_out,
  output logic                    o_a_load,
  output logic                    o_a_out,
  output logic                    o_b_load,
  output logic                    o_alu_sub,
  output logic                    o_alu_out,
  output logic                    o_flags_load,
  output logic                    o_out_load,
  output logic                    o_halt
);

  step_t               step;
  logic                halted;
  logic [CW_WIDTH-1:0] ctrl;
  logic [CW_WIDTH-1:0] ctrl_gated;
  logic                last_step;

  microcode_decode #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_decode (
    .step      (step),
    .opcode    (i_opcode),
    .carry     (i_flag_carry),
    .zero      (i_flag_zero),
    .ctrl      (ctrl),
    .last_step (last_step)
  );

  // Once halted the step stays at T3 (where HLT was decoded) until reset.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      step   <= T1;
      halted <= 1'b0;
    end else if (mclk_en && !halted) begin
      if (ctrl[CW_HLT]) begin
        halted <= 1'b1;
      end else if (last_step) begin
        step <= T1;
      end else begin
        step <= step_t'(step + 3'd1);
      end
    end
  end

  assign ctrl_gated = halted ? '0 : ctrl;

  assign o_step       = step;
  assign o_halt       = halted;
  assign o_pc_inc     = ctrl_gated[CW_PC_INC];
  assign o_pc_out     = ctrl_gated[CW_PC_OUT];
  assign o_pc_load    = ctrl_gated[CW_PC_LOAD];
  assign o_mar_load   = ctrl_gated[CW_MAR_LOAD];
  assign o_ram_out    = ctrl_gated[CW_RAM_OUT];
  assign o_ram_load   = ctrl_gated[CW_RAM_LOAD];
  assign o_ir_load    = ctrl_gated[CW_IR_LOAD];
  assign o_ir_out     = ctrl_gated[CW_IR_OUT];
  assign o_a_load     = ctrl_gated[CW_A_LOAD];
  assign o_a_out      = ctrl_gated[CW_A_OUT];
  assign o_b_load     = ctrl_gated[CW_B_LOAD];
  assign o_alu_sub    = ctrl_gated[CW_ALU_SUB];
  assign o_alu_out    = ctrl_gated[CW_ALU_OUT];
  assign o_flags_load = ctrl_gated[CW_FLAGS_LOAD];
  assign o_out_load   = ctrl_gated[CW_OUT_LOAD];

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - self-checking bench for controller_sequencer
module tb_controller_sequencer;

  logic       mclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mclk_en = 1'b1;
  logic [3:0] i_opcode = 4'd0;
  logic       i_flag_carry = 1'b0;
  logic       i_flag_zero = 1'b0;
  logic [2:0] o_step;
  logic o_pc_inc, o_pc_out, o_pc_load, o_mar_load, o_ram_out, o_ram_load;
  logic o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_sub;
  logic o_alu_out, o_flags_load, o_out_load, o_halt;

  int n_checks = 0;
  int n_fail = 0;

  controller_sequencer #(.OPCODE_WIDTH(4)) dut (
    .mclk(mclk), .rst_n(rst_n), .mclk_en(mclk_en), .i_opcode(i_opcode),
    .i_flag_carry(i_flag_carry), .i_flag_zero(i_flag_zero), .o_step(o_step),
    .o_pc_inc(o_pc_inc), .o_pc_out(o_pc_out), .o_pc_load(o_pc_load),
    .o_mar_load(o_mar_load), .o_ram_out(o_ram_out), .o_ram_load(o_ram_load),
    .o_ir_load(o_ir_load), .o_ir_out(o_ir_out), .o_a_load(o_a_load),
    .o_a_out(o_a_out), .o_b_load(o_b_load), .o_alu_sub(o_alu_sub),
    .o_alu_out(o_alu_out), .o_flags_load(o_flags_load),
    .o_out_load(o_out_load), .o_halt(o_halt)
  );

  always #5 mclk = ~mclk;

  // Bench-side naming of the control lines, one bit each.
  localparam logic [15:0] PC_INC = 16'h8000, PC_OUT = 16'h4000, PC_LOAD = 16'h2000,
                          MAR_LOAD = 16'h1000, RAM_OUT = 16'h0800, RAM_LOAD = 16'h0400,
                          IR_LOAD = 16'h0200, IR_OUT = 16'h0100, A_LOAD = 16'h0080,
                          A_OUT = 16'h0040, B_LOAD = 16'h0020, ALU_SUB = 16'h0010,
                          ALU_OUT = 16'h0008, FLAGS_LOAD = 16'h0004, OUT_LOAD = 16'h0002,
                          HALT = 16'h0001;
  localparam logic [15:0] BUS_MASK = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;
  localparam logic [15:0] FETCH1 = PC_OUT | MAR_LOAD;
  localparam logic [15:0] FETCH2 = RAM_OUT | IR_LOAD | PC_INC;

  logic [15:0] dut_word;
  assign dut_word = {o_pc_inc, o_pc_out, o_pc_load, o_mar_load, o_ram_out, o_ram_load,
                     o_ir_load, o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_sub,
                     o_alu_out, o_flags_load, o_out_load, o_halt};

  // Instruction length in enabled cycles, fetch included.
  function automatic int instr_len(int op);
    case (op)
      0, 4:    return 4;
      1, 2:    return 5;
      default: return 3;
    endcase
  endfunction

  // What the datapath must see in a given step of a given instruction.
  function automatic logic [15:0] exp_word(int st, int op, bit c, bit z, bit h);
    if (h) return HALT;
    if (st == 0) return FETCH1;
    if (st == 1) return FETCH2;
    case (op)
      0: return (st == 2) ? (IR_OUT | MAR_LOAD) : (RAM_OUT | A_LOAD);
      4: return (st == 2) ? (IR_OUT | MAR_LOAD) : (A_OUT | RAM_LOAD);
      1, 2: begin
        if (st == 2) return IR_OUT | MAR_LOAD;
        if (st == 3) return RAM_OUT | B_LOAD;
        return ALU_OUT | A_LOAD | FLAGS_LOAD | ((op == 2) ? ALU_SUB : 16'h0);
      end
      5:  return IR_OUT | A_LOAD;
      6:  return IR_OUT | PC_LOAD;
      7:  return c ? (IR_OUT | PC_LOAD) : 16'h0;
      8:  return z ? (IR_OUT | PC_LOAD) : 16'h0;
      14: return A_OUT | OUT_LOAD;
      default: return 16'h0;
    endcase
  endfunction

  // Reference state: where in the instruction we are, and whether halted.
  int m_step = 0;
  bit m_halt = 1'b0;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= 0;
      m_halt <= 1'b0;
    end else if (mclk_en && !m_halt) begin
      if (m_step == 2 && i_opcode == 4'd15) m_halt <= 1'b1;
      else if (m_step + 1 >= instr_len(int'(i_opcode))) m_step <= 0;
      else m_step <= m_step + 1;
    end
  end

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge mclk) begin
    check("cyc_step", {13'd0, o_step}, 16'(m_step));
    check("cyc_ctrl", dut_word,
          exp_word(m_step, int'(i_opcode), i_flag_carry, i_flag_zero, m_halt));
    check("cyc_bus", 16'($countones(dut_word & BUS_MASK) <= 1), 16'd1);
    check("cyc_pc", 16'(o_pc_inc & o_pc_load), 16'd0);
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic lit(string name, logic [15:0] w, int s);
    #1;
    check({name, "_ctrl"}, dut_word, w);
    check({name, "_step"}, {13'd0, o_step}, 16'(s));
  endtask

  task automatic run_to(int s, string name);
    int k = 0;
    while (m_step != s && k < 12) begin
      tick();
      k++;
    end
    check(name, {13'd0, o_step}, 16'(s));
  endtask

  initial begin
    // Reset and fetch.
    tick();
    tick();
    lit("reset", FETCH1, 0);
    rst_n = 1'b1;
    i_opcode = 4'd1;
    tick(); lit("add_t2", FETCH2, 1);
    tick(); lit("add_t3", IR_OUT | MAR_LOAD, 2);
    tick(); lit("add_t4", RAM_OUT | B_LOAD, 3);
    tick(); lit("add_t5", ALU_OUT | A_LOAD | FLAGS_LOAD, 4);
    tick(); lit("add_ret", FETCH1, 0);

    // JC, carry clear then set; flag dropped inside T3.
    i_opcode = 4'd7;
    tick(); tick(); lit("jc_nc", 16'h0, 2);
    tick(); lit("jc_nc_ret", FETCH1, 0);
    i_flag_carry = 1'b1;
    tick(); tick(); lit("jc_c", IR_OUT | PC_LOAD, 2);
    i_flag_carry = 1'b0;
    lit("jc_drop", 16'h0, 2);
    tick();
    // JZ likewise.
    i_opcode = 4'd8;
    tick(); tick(); lit("jz_nz", 16'h0, 2);
    tick();
    i_flag_zero = 1'b1;
    tick(); tick(); lit("jz_z", IR_OUT | PC_LOAD, 2);
    tick();
    i_flag_zero = 1'b0;

    // LDA with a 1-of-3 clock enable.
    i_opcode = 4'd0;
    for (int i = 0; i < 15; i++) begin
      mclk_en = (i % 3 == 0);
      tick();
    end
    mclk_en = 1'b1;
    run_to(0, "lda_drain");

    // Randomised traffic with occasional resets, halt excluded.
    for (int i = 0; i < 3000; i++) begin
      tick();
      mclk_en = ($urandom % 4) != 0;
      i_flag_carry = $urandom % 2;
      i_flag_zero = $urandom % 2;
      rst_n = ($urandom % 100) != 0;
      if (m_step < 2) i_opcode = 4'($urandom_range(0, 14));
    end
    rst_n = 1'b1;
    mclk_en = 1'b1;
    run_to(0, "rand_drain");

    // Reset during T4 of SUB.
    i_opcode = 4'd2;
    run_to(3, "sub_to_t4");
    lit("sub_t4", RAM_OUT | B_LOAD, 3);
    rst_n = 1'b0;
    lit("sub_rst", FETCH1, 0);
    tick();
    rst_n = 1'b1;
    tick(); lit("sub_resume", FETCH2, 1);
    run_to(0, "sub_drain");

    // Halt: frozen at T3 regardless of enable, cleared only by reset.
    i_opcode = 4'd15;
    run_to(2, "hlt_to_t3");
    lit("hlt_t3", 16'h0, 2);
    tick(); lit("halt", HALT, 2);
    for (int i = 0; i < 20; i++) begin
      mclk_en = $urandom % 2;
      tick();
    end
    lit("halt_hold", HALT, 2);
    mclk_en = 1'b1;
    #1;
    rst_n = 1'b0;
    lit("halt_rst", FETCH1, 0);
    tick();
    i_opcode = 4'd5;
    rst_n = 1'b1;
    tick(); lit("post_rst", FETCH2, 1);
    tick(); lit("ldi_t3", IR_OUT | A_LOAD, 2);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

Microcoded control sequencer for the SAP-1 style CPU. It steps a T-state counter on every enabled clock and decodes the current step and the instruction-register opcode into the control word. The control word drives the program counter, the memory address register, RAM, the instruction register, the A and B registers, the ALU, the flags register and the output register. It owns the sticky halt condition, which also feeds the program counter's halt input.

## Interface
- `OPCODE_WIDTH`, default 4: width of the opcode field from the instruction register.
- `mclk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mclk_en` in 1: clock enable; state advances only on edges where it is 1.
- `i_opcode` in OPCODE_WIDTH: upper field of the instruction register.
- `i_flag_carry` in 1: registered carry flag.
- `i_flag_zero` in 1: registered zero flag.
- `o_step` out 3: current T-state, 0=T1 … 4=T5.
- Control outputs, each `out 1`:
  - `o_pc_inc`, `o_pc_out`, `o_pc_load`
  - `o_mar_load`
  - `o_ram_out`, `o_ram_load`
  - `o_ir_load`, `o_ir_out`
  - `o_a_load`, `o_a_out`
  - `o_b_load`
  - `o_alu_sub`, `o_alu_out`
  - `o_flags_load`
  - `o_out_load`
  - `o_halt`

## Operation
- **Opcodes:** LDA=0, ADD=1, SUB=2, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=14, HLT=15. All other opcodes are NOP.
- **Fetch, all opcodes:**
  - T1: `o_pc_out`, `o_mar_load`.
  - T2: `o_ram_out`, `o_ir_load`, `o_pc_inc`.
- **Execute:**
  - LDA: T3 `o_ir_out`+`o_mar_load`; T4 `o_ram_out`+`o_a_load`; last step T4.
  - ADD: T3 `o_ir_out`+`o_mar_load`; T4 `o_ram_out`+`o_b_load`; T5 `o_alu_out`+`o_a_load`+`o_flags_load`; last step T5.
  - SUB: same as ADD, with `o_alu_sub` also asserted in T5.
  - STA: T3 `o_ir_out`+`o_mar_load`; T4 `o_a_out`+`o_ram_load`; last step T4.
  - LDI: T3 `o_ir_out`+`o_a_load`; last step T3.
  - JMP: T3 `o_ir_out`+`o_pc_load`; last step T3.
  - JC / JZ: T3 `o_ir_out`+`o_pc_load` only when `i_flag_carry` / `i_flag_zero` is 1; otherwise no controls. Last step T3.
  - OUT: T3 `o_a_out`+`o_out_load`; last step T3.
  - NOP: T3 has no controls; last step T3.
  - HLT: at T3 the halt register is set on the next enabled edge.
- **Step transitions:** on an enabled edge the step increments; from an opcode's last step it returns to T1. No unused T-states are burned.
- **Halt:**
  - Once the halt register is set, `o_halt`=1 and the step freezes at T3. All other control outputs are 0.
  - Only reset clears halt.
- **Bus rule:** at most one of `o_pc_out`, `o_ram_out`, `o_ir_out`, `o_a_out`, `o_alu_out` is 1 in any cycle.
- **Program counter rule:** `o_pc_inc` and `o_pc_load` are never 1 together.
- **Reset values:** step=T1, halt=0. Outputs follow from that state: `o_pc_out`=1, `o_mar_load`=1, all other controls 0, `o_step`=0.

## Timing
- Step and halt registers update only on `posedge mclk` with `mclk_en`=1. When `mclk_en`=0 they hold indefinitely.
- Control outputs are combinational from step, halt, `i_opcode` and the flags. They are valid for the whole cycle preceding the enabled edge on which consumers sample them.
- `i_opcode` is used only in T3–T5. It is stable then because IR loads at the end of T2.
- Instruction length in enabled cycles: LDA/STA 4; ADD/SUB 5; LDI/JMP/JC/JZ/OUT/NOP 3.
- Reset asserted mid-instruction forces step=T1 and halt=0 immediately, asynchronously. Release takes effect on the next enabled edge.
- Flags are sampled combinationally in T3 of JC/JZ. A flag change within T3 changes `o_pc_load` in the same cycle.

## Structure
- Shared package holds:
  - opcode constants, width = `OPCODE_WIDTH`
  - T-state encodings T1..T5
  - control-word bit index constants, so the datapath top level unpacks by name
- One sub-module, `microcode_decode`: purely combinational, mapping (step, opcode, carry, zero) to (control word, last_step).
- `controller_sequencer` keeps only the step counter, the halt register and output gating.

## Test plan
- **Reset/fetch:** drop `rst_n`, release, `mclk_en`=1 → T1 shows `o_pc_out`=1 and `o_mar_load`=1; next cycle T2 shows `o_ram_out`, `o_ir_load`, `o_pc_inc`; `o_step` goes 0,1,2.
- **ADD sequence:** `i_opcode`=1 → T3–T5 controls exactly as listed; step returns to 0 after T5; every cycle checked for a single bus driver.
- **Conditional jump:** `i_opcode`=7 with `i_flag_carry`=0 → T3 has no controls and the next step is T1. With carry=1 → T3 asserts `o_ir_out` and `o_pc_load`. Repeat for JZ using `i_flag_zero`.
- **Clock enable:** toggle `mclk_en` in a 1-of-3 pattern during LDA → step advances only on enabled edges; controls hold across the stalled cycles.
- **Halt:** `i_opcode`=15 → after the T3 enabled edge, `o_halt`=1 and all else 0; step frozen at 2 for 20 cycles regardless of `mclk_en`. Then `rst_n`=0 → halt=0 and step=0 without a clock edge.
- **Mid-instruction reset:** assert `rst_n`=0 at T4 of SUB → outputs revert to the T1 pattern the same cycle; normal fetch resumes after release.
